alarm_responder: RTL and testbench

- Consumer end of the alarm event interface: takes the `beeb` trigger from the alarm timer and drives the audible buzzer pattern.
- Handles user acknowledge and snooze, with a bounded snooze count and an unattended-ring timeout.
- Sits between the alarm timer and the buzzer driver/user buttons.
- One clock-enable-free domain: `clock` is the 1 Hz system tick, so one cycle = 1 s.

---
 rtl/alarm_responder.sv | 155 +++++++++++++++
 tb/tb_alarm_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_responder.sv
// Alarm responder: turns the alarm timer's beeb trigger into a buzzer pattern with ack/snooze handling.
// Optional ALARM_AUTO_SNOOZE_EN: an unanswered ring auto-snoozes while snoozes remain.
module alarm_responder #(
  parameter int unsigned SNOOZE_SECS  = 5,
  parameter int unsigned MAX_SNOOZE   = 3,
  parameter int unsigned RING_TIMEOUT = 20,
  parameter int unsigned BUZZ_ON      = 2,
  parameter int unsigned BUZZ_OFF     = 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                beeb,
  input  logic                                ack,
  input  logic                                snooze,
  output logic                                buzzer,
  output logic                                ringing,
  output logic                                snoozing,
  output logic [$clog2(MAX_SNOOZE+1)-1:0]     snooze_cnt,
  output logic                                missed
);

  localparam int unsigned PERIOD = BUZZ_ON + BUZZ_OFF;
  localparam int unsigned PW     = $clog2(PERIOD + 1);
  localparam int unsigned RW     = $clog2(RING_TIMEOUT + 1);
  localparam int unsigned SW     = $clog2(SNOOZE_SECS + 1);
  localparam int unsigned CW     = $clog2(MAX_SNOOZE + 1);

  localparam logic [PW-1:0] PAT_LAST  = PW'(PERIOD - 1);
  localparam logic [PW-1:0] PAT_ON    = PW'(BUZZ_ON);
  localparam logic [RW-1:0] RING_MAX  = RW'(RING_TIMEOUT);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_SECS);
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_SNOOZE);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

  state_t          state_q, state_n;
  logic            beeb_d;
  logic [PW-1:0]   pat_q, pat_n;
  logic [RW-1:0]   ring_q, ring_n;
  logic [SW-1:0]   snz_q, snz_n;
  logic [CW-1:0]   cnt_n;
  logic            missed_n;
  logic            enter_ring;
  logic            trig;
  logic            buzzer_n, ringing_n, snoozing_n;

  assign trig = beeb & ~beeb_d;

  // State, timers and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      beeb_d     <= 1'b1;
      pat_q      <= '0;
      ring_q     <= '0;
      snz_q      <= '0;
      snooze_cnt <= '0;
      missed     <= 1'b0;
      buzzer     <= 1'b0;
      ringing    <= 1'b0;
      snoozing   <= 1'b0;
    end else begin
      state_q    <= state_n;
      beeb_d     <= beeb;
      pat_q      <= pat_n;
      ring_q     <= ring_n;
      snz_q      <= snz_n;
      snooze_cnt <= cnt_n;
      missed     <= missed_n;
      buzzer     <= buzzer_n;
      ringing    <= ringing_n;
      snoozing   <= snoozing_n;
    end
  end

  // Next-state, timer and output decode
  always_comb begin
    state_n    = state_q;
    pat_n      = pat_q;
    ring_n     = ring_q;
    snz_n      = snz_q;
    cnt_n      = snooze_cnt;
    missed_n   = missed;
    enter_ring = 1'b0;

    case (state_q)
      IDLE: begin
        if (trig) begin
          state_n    = RING;
          enter_ring = 1'b1;
          cnt_n      = '0;
          missed_n   = 1'b0;
        end
      end
      RING: begin
        if (ack) begin
          state_n  = IDLE;
          cnt_n    = '0;
          missed_n = 1'b0;
        end else if (snooze && (snooze_cnt < CNT_MAX)) begin
          state_n = SNOOZE;
          cnt_n   = snooze_cnt + CW'(1);
          snz_n   = SNZ_LOAD;
        end else if (ring_q >= RING_MAX) begin
`ifdef ALARM_AUTO_SNOOZE_EN
          if (snooze_cnt < CNT_MAX) begin
            state_n = SNOOZE;
            cnt_n   = snooze_cnt + CW'(1);
            snz_n   = SNZ_LOAD;
          end else begin
            state_n  = IDLE;
            missed_n = 1'b1;
          end
`else
          state_n  = IDLE;
          missed_n = 1'b1;
`endif
        end else begin
          ring_n = ring_q + RW'(1);
          pat_n  = (pat_q == PAT_LAST) ? '0 : pat_q + PW'(1);
        end
      end
      SNOOZE: begin
        if (ack) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (trig || (snz_q <= SW'(1))) begin
          state_n    = RING;
          enter_ring = 1'b1;
        end else begin
          snz_n = snz_q - SW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // ring_q counts RING cycles including the current one, so entry loads 1
    if (enter_ring) begin
      pat_n  = '0;
      ring_n = RW'(1);
    end
    if (state_n != RING) begin
      pat_n  = '0;
      ring_n = '0;
    end
    if (state_n != SNOOZE) begin
      snz_n = '0;
    end

    ringing_n  = (state_n == RING);
    snoozing_n = (state_n == SNOOZE);
    buzzer_n   = (state_n == RING) && (pat_n < PAT_ON);
  end

endmodule

// File: tb/tb_alarm_responder.sv
// Directed bench for alarm_responder with default parameters; expectations are hand-derived.
module tb_alarm_responder;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       beeb = 1'b0;
  logic       ack = 1'b0;
  logic       snooze = 1'b0;
  logic       buzzer, ringing, snoozing, missed;
  logic [1:0] snooze_cnt;

  int errors = 0;
  int checks = 0;

  alarm_responder dut (
    .clock      (clock),
    .reset      (reset),
    .beeb       (beeb),
    .ack        (ack),
    .snooze     (snooze),
    .buzzer     (buzzer),
    .ringing    (ringing),
    .snoozing   (snoozing),
    .snooze_cnt (snooze_cnt),
    .missed     (missed)
  );

  always #5 clock = ~clock;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    beeb   = 1'b0;
    ack    = 1'b0;
    snooze = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Raise beeb for one sampled edge; returns in the first RING cycle
  task automatic start_ring();
    beeb = 1'b1;
    tick();
    beeb = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    checks++;
    if ({buzzer, ringing, snoozing, snooze_cnt, missed} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000", {buzzer, ringing, snoozing, snooze_cnt, missed});
    end
    do_reset();
  endtask

  task automatic test_pattern();
    logic [5:0] exp_buz;
    exp_buz = 6'b110110;
    do_reset();
    tick();
    start_ring();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({ringing, buzzer} !== {1'b1, exp_buz[5-i]}) begin
        errors++;
        $display("FAIL pattern[%0d]: ringing/buzzer=%b%b expected 1%b", i, ringing, buzzer, exp_buz[5-i]);
      end
      tick();
    end
  endtask

  task automatic test_ack();
    do_reset();
    start_ring();
    tick();
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if ({buzzer, ringing, snoozing, snooze_cnt} !== 5'b0) begin
      errors++;
      $display("FAIL ack_idle: got %b expected 00000", {buzzer, ringing, snoozing, snooze_cnt});
    end
    tick();
    tick();
    checks++;
    if (ringing !== 1'b0) begin
      errors++;
      $display("FAIL ack_stays_idle: ringing=%b expected 0", ringing);
    end
  endtask

  task automatic test_snooze();
    do_reset();
    start_ring();
    for (int k = 1; k <= 3; k++) begin
      snooze = 1'b1;
      tick();
      snooze = 1'b0;
      for (int j = 0; j < 5; j++) begin
        checks++;
        if ({snoozing, buzzer, ringing, snooze_cnt} !== {3'b100, 2'(k)}) begin
          errors++;
          $display("FAIL snooze%0d_cycle%0d: snz/buz/ring/cnt=%b expected %b", k, j,
                   {snoozing, buzzer, ringing, snooze_cnt}, {3'b100, 2'(k)});
        end
        tick();
      end
      checks++;
      if ({ringing, buzzer, snoozing} !== 3'b110) begin
        errors++;
        $display("FAIL snooze%0d_rering: ring/buz/snz=%b expected 110", k, {ringing, buzzer, snoozing});
      end
    end
    // Fourth snooze exceeds the limit and must be ignored
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    checks++;
    if ({ringing, snoozing, buzzer, snooze_cnt} !== 5'b10111) begin
      errors++;
      $display("FAIL snooze_limit: ring/snz/buz/cnt=%b expected 10111", {ringing, snoozing, buzzer, snooze_cnt});
    end
    tick();
    checks++;
    if ({ringing, buzzer} !== 2'b10) begin
      errors++;
      $display("FAIL snooze_limit_pattern: ring/buz=%b expected 10", {ringing, buzzer});
    end
  endtask

  task automatic test_snooze_trig();
    do_reset();
    start_ring();
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    beeb = 1'b1;
    tick();
    beeb = 1'b0;
    checks++;
    if ({ringing, buzzer, snoozing, snooze_cnt} !== 5'b11001) begin
      errors++;
      $display("FAIL snooze_trig: ring/buz/snz/cnt=%b expected 11001", {ringing, buzzer, snoozing, snooze_cnt});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    start_ring();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (ringing !== 1'b1) begin
        errors++;
        $display("FAIL timeout_ring[%0d]: ringing=%b expected 1", i, ringing);
      end
      tick();
    end
`ifdef ALARM_AUTO_SNOOZE_EN
    checks++;
    if ({ringing, snoozing, missed, snooze_cnt} !== 5'b01001) begin
      errors++;
      $display("FAIL timeout_auto: ring/snz/missed/cnt=%b expected 01001", {ringing, snoozing, missed, snooze_cnt});
    end
`else
    checks++;
    if ({ringing, snoozing, missed, snooze_cnt} !== 5'b00100) begin
      errors++;
      $display("FAIL timeout_missed: ring/snz/missed/cnt=%b expected 00100", {ringing, snoozing, missed, snooze_cnt});
    end
`endif
    start_ring();
    checks++;
    if ({ringing, missed} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_rering: ring/missed=%b expected 10", {ringing, missed});
    end
  endtask

  task automatic test_ack_and_snooze();
    do_reset();
    start_ring();
    ack    = 1'b1;
    snooze = 1'b1;
    tick();
    ack    = 1'b0;
    snooze = 1'b0;
    checks++;
    if ({ringing, snoozing, snooze_cnt} !== 4'b0) begin
      errors++;
      $display("FAIL ack_wins: ring/snz/cnt=%b expected 0000", {ringing, snoozing, snooze_cnt});
    end
  endtask

  task automatic test_beeb_held();
    reset = 1'b0;
    beeb  = 1'b1;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ringing !== 1'b0) begin
        errors++;
        $display("FAIL beeb_held[%0d]: ringing=%b expected 0", i, ringing);
      end
    end
    beeb = 1'b0;
  endtask

  task automatic test_reset_mid_snooze();
    do_reset();
    start_ring();
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    tick();
    checks++;
    if (snoozing !== 1'b1) begin
      errors++;
      $display("FAIL mid_snooze_setup: snoozing=%b expected 1", snoozing);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({buzzer, ringing, snoozing, snooze_cnt, missed} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset: got %b expected 000000", {buzzer, ringing, snoozing, snooze_cnt, missed});
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if ({ringing, snoozing} !== 2'b00) begin
        errors++;
        $display("FAIL post_reset_idle[%0d]: ring/snz=%b expected 00", i, {ringing, snoozing});
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_ack();
    test_snooze();
    test_snooze_trig();
    test_timeout();
    test_ack_and_snooze();
    test_beeb_held();
    test_reset_mid_snooze();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
